// File: rtl/rf_systolic_mm4.sv
// rtl/rf_systolic_mm4.sv - operand register file feeding a 4x4 output-stationary systolic MAC array
// Optional macro RF_SYSTOLIC_SIGNED_EN selects two's-complement operands and accumulation.
module rf_systolic_mm4 #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             write,
    input  logic [1:0]       idx,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [ACC_W-1:0] y0,
    output logic [ACC_W-1:0] y1,
    output logic [ACC_W-1:0] y2,
    output logic [ACC_W-1:0] y3,
    output logic [ACC_W-1:0] y4,
    output logic [ACC_W-1:0] y5,
    output logic [ACC_W-1:0] y6,
    output logic [ACC_W-1:0] y7,
    output logic [ACC_W-1:0] y8,
    output logic [ACC_W-1:0] y9,
    output logic [ACC_W-1:0] y10,
    output logic [ACC_W-1:0] y11,
    output logic [ACC_W-1:0] y12,
    output logic [ACC_W-1:0] y13,
    output logic [ACC_W-1:0] y14,
    output logic [ACC_W-1:0] y15,
    output logic             done
);

    // Last operand pair reaches PE(3,3) at step 3*(SIZE-1), so a pass is 3*SIZE-2 steps.
    localparam logic [3:0] STEPS = 4'(3 * SIZE - 2);

    logic [WIDTH-1:0]   r_a   [SIZE][SIZE];
    logic [WIDTH-1:0]   r_b   [SIZE][SIZE];
    logic [WIDTH-1:0]   r_pa  [SIZE][SIZE];
    logic [WIDTH-1:0]   r_pb  [SIZE][SIZE];
    logic [ACC_W-1:0]   r_acc [SIZE][SIZE];
    logic [3:0]         r_t;

    logic [WIDTH-1:0]   w_d      [8];
    logic [WIDTH-1:0]   w_edge_a [SIZE];
    logic [WIDTH-1:0]   w_edge_b [SIZE];
    logic [WIDTH-1:0]   w_ain    [SIZE][SIZE];
    logic [WIDTH-1:0]   w_bin    [SIZE][SIZE];
    logic [ACC_W-1:0]   w_prod   [SIZE][SIZE];
    logic [1:0]         w_row_lo;
    logic [1:0]         w_row_hi;
    logic               w_compute;

    assign w_d[0] = d0;
    assign w_d[1] = d1;
    assign w_d[2] = d2;
    assign w_d[3] = d3;
    assign w_d[4] = d4;
    assign w_d[5] = d5;
    assign w_d[6] = d6;
    assign w_d[7] = d7;

    assign w_row_lo  = {idx[0], 1'b0};
    assign w_row_hi  = {idx[0], 1'b1};
    assign w_compute = (r_t != STEPS);
    assign done      = (r_t == STEPS);

    // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j], zero outside the matrix.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            automatic int k = int'(r_t) - i;
            w_edge_a[i] = '0;
            w_edge_b[i] = '0;
            if (k >= 0 && k < SIZE) begin
                w_edge_a[i] = r_a[i][k[1:0]];
                w_edge_b[i] = r_b[k[1:0]][i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                w_ain[i][j] = (j == 0) ? w_edge_a[i] : r_pa[i][(j == 0) ? 0 : j - 1];
                w_bin[i][j] = (i == 0) ? w_edge_b[j] : r_pb[(i == 0) ? 0 : i - 1][j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
`ifdef RF_SYSTOLIC_SIGNED_EN
                automatic logic signed [2*WIDTH-1:0] p = $signed(w_ain[i][j]) * $signed(w_bin[i][j]);
                w_prod[i][j] = {{(ACC_W - 2*WIDTH){p[2*WIDTH-1]}}, p};
`else
                automatic logic [2*WIDTH-1:0] p = w_ain[i][j] * w_bin[i][j];
                w_prod[i][j] = {{(ACC_W - 2*WIDTH){1'b0}}, p};
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_t <= '0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    r_a[i][j]   <= '0;
                    r_b[i][j]   <= '0;
                    r_pa[i][j]  <= '0;
                    r_pb[i][j]  <= '0;
                    r_acc[i][j] <= '0;
                end
            end
        end else if (enable) begin
            if (write) begin
                // Any load restarts the pass so stale partial sums never mix with new operands.
                r_t <= '0;
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        r_pa[i][j]  <= '0;
                        r_pb[i][j]  <= '0;
                        r_acc[i][j] <= '0;
                    end
                end
                for (int c = 0; c < SIZE; c++) begin
                    if (!idx[1]) begin
                        r_a[w_row_lo][c] <= w_d[c];
                        r_a[w_row_hi][c] <= w_d[c+4];
                    end else begin
                        r_b[w_row_lo][c] <= w_d[c];
                        r_b[w_row_hi][c] <= w_d[c+4];
                    end
                end
            end else if (w_compute) begin
                r_t <= r_t + 4'd1;
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        r_pa[i][j]  <= w_ain[i][j];
                        r_pb[i][j]  <= w_bin[i][j];
                        r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
                    end
                end
            end
        end
    end

    assign y0  = r_acc[0][0];
    assign y1  = r_acc[0][1];
    assign y2  = r_acc[0][2];
    assign y3  = r_acc[0][3];
    assign y4  = r_acc[1][0];
    assign y5  = r_acc[1][1];
    assign y6  = r_acc[1][2];
    assign y7  = r_acc[1][3];
    assign y8  = r_acc[2][0];
    assign y9  = r_acc[2][1];
    assign y10 = r_acc[2][2];
    assign y11 = r_acc[2][3];
    assign y12 = r_acc[3][0];
    assign y13 = r_acc[3][1];
    assign y14 = r_acc[3][2];
    assign y15 = r_acc[3][3];

endmodule

// File: tb/tb_rf_systolic_mm4.sv
// tb/tb_rf_systolic_mm4.sv - directed self-checking bench for rf_systolic_mm4
module tb_rf_systolic_mm4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        write;
    logic [1:0]  idx;
    logic [7:0]  d [8];
    logic [17:0] y [16];
    logic        done;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rf_systolic_mm4 dut (
        .clk(clk), .reset(reset), .enable(enable), .write(write), .idx(idx),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
        .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
        .y8(y[8]), .y9(y[9]), .y10(y[10]), .y11(y[11]),
        .y12(y[12]), .y13(y[13]), .y14(y[14]), .y15(y[15]),
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] slot, input logic [63:0] bytes);
        enable = 1'b1;
        write  = 1'b1;
        idx    = slot;
        for (int k = 0; k < 8; k++) d[k] = bytes[8*k +: 8];
        tick();
        enable = 1'b0;
        write  = 1'b0;
    endtask

    task automatic compute(input int n);
        enable = 1'b1;
        write  = 1'b0;
        repeat (n) tick();
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_y(input string tag, input logic [17:0] exp [16]);
        for (int k = 0; k < 16; k++) check($sformatf("%s_y%0d", tag, k), 32'(y[k]), 32'(exp[k]));
    endtask

    localparam logic [63:0] ID_LO  = 64'h0000_0100_0000_0001;
    localparam logic [63:0] ID_HI  = 64'h0100_0000_0001_0000;
    localparam logic [63:0] SEQ_LO = 64'h0807_0605_0403_0201;
    localparam logic [63:0] SEQ_HI = 64'h100F_0E0D_0C0B_0A09;
    localparam logic [63:0] ONES   = 64'h0101_0101_0101_0101;

    logic [17:0] exp_y [16];

    initial begin
        reset = 1'b1; enable = 1'b0; write = 1'b0; idx = 2'd0;
        for (int k = 0; k < 8; k++) d[k] = 8'd0;
        tick();
        tick();
        reset = 1'b0;

        for (int k = 0; k < 16; k++) exp_y[k] = 18'd0;
        check("reset_done", 32'(done), 32'd0);
        check_y("reset", exp_y);

        // Identity A times B[r][c] = 4r+c+1
        load(2'd0, ID_LO);
        load(2'd1, ID_HI);
        load(2'd2, SEQ_LO);
        load(2'd3, SEQ_HI);
        compute(9);
        check("ident_done_9", 32'(done), 32'd0);
        compute(1);
        check("ident_done_10", 32'(done), 32'd1);
        for (int k = 0; k < 16; k++) exp_y[k] = 18'(k + 1);
        check_y("ident", exp_y);
        compute(3);
        check("ident_hold_done", 32'(done), 32'd1);
        check_y("ident_hold", exp_y);

        // Pause of 3 cycles at t = 5
        load(2'd3, SEQ_HI);
        compute(5);
        idle(3);
        check("pause_done_idle", 32'(done), 32'd0);
        compute(4);
        check("pause_done_9", 32'(done), 32'd0);
        compute(1);
        check("pause_done_10", 32'(done), 32'd1);
        check_y("pause", exp_y);

        // Abort at t = 4 by reloading B with all ones
        load(2'd3, SEQ_HI);
        compute(4);
        load(2'd2, ONES);
        check("abort_clear_y0", 32'(y[0]), 32'd0);
        check("abort_clear_done", 32'(done), 32'd0);
        load(2'd3, ONES);
        compute(9);
        check("abort_done_9", 32'(done), 32'd0);
        compute(1);
        check("abort_done_10", 32'(done), 32'd1);
        for (int k = 0; k < 16; k++) exp_y[k] = 18'd1;
        check_y("abort", exp_y);

        // Saturation corner
`ifdef RF_SYSTOLIC_SIGNED_EN
        load(2'd0, '1);
        load(2'd1, '1);
        load(2'd2, 64'h0202_0202_0202_0202);
        load(2'd3, 64'h0202_0202_0202_0202);
        for (int k = 0; k < 16; k++) exp_y[k] = 18'h3FFF8;
`else
        load(2'd0, '1);
        load(2'd1, '1);
        load(2'd2, '1);
        load(2'd3, '1);
        for (int k = 0; k < 16; k++) exp_y[k] = 18'd260100;
`endif
        compute(10);
        check("sat_done", 32'(done), 32'd1);
        check_y("sat", exp_y);

        // Reset with enable low wipes operands and results
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) exp_y[k] = 18'd0;
        check("rst2_done", 32'(done), 32'd0);
        check_y("rst2", exp_y);
        compute(10);
        check("rst2_pass_done", 32'(done), 32'd1);
        check_y("rst2_pass", exp_y);

        // Load mapping: A rows 2-3 = 1..8, B = I
        load(2'd1, SEQ_LO);
        load(2'd2, ID_LO);
        load(2'd3, ID_HI);
        compute(10);
        check("map_done", 32'(done), 32'd1);
        for (int k = 0; k < 16; k++) exp_y[k] = (k >= 8) ? 18'(k - 7) : 18'd0;
        check_y("map", exp_y);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_systolic_mm4.md
# rf_systolic_mm4

Matrix-multiply core for the fast multiplier: an operand register file plus a 4x4 output-stationary systolic array of multiply-accumulate PEs. The host loads two 4x4 byte matrices A and B, eight bytes per write cycle. Compute cycles then stream skewed rows of A and columns of B through the array, producing C = A x B on sixteen accumulator outputs. It sits directly under the `systolic_array` wrapper, which supplies input buffering.

## Interface
Parameters:
- `SIZE`, 4: array dimension. Only 4 is supported.
- `WIDTH`, 8: operand width.
- `ACC_W`, 18: accumulator and output width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  global clock enable; when low, all state holds.
- `write`  in  1  high: load cycle. Low: compute cycle.
- `idx`  in  2  load slot: 0 = A rows 0-1, 1 = A rows 2-3, 2 = B rows 0-1, 3 = B rows 2-3.
- `d0`..`d7`  in  WIDTH each  load data. `d0..d3` go to the lower row of the slot, columns 0..3. `d4..d7` go to the upper row, columns 0..3.
- `y0`..`y15`  out  ACC_W each  `y(4i+j)` = accumulator of PE(i,j) = C[i][j].
- `done`  out  1  high once C is complete.

## Operation
- Storage: A[4][4], B[4][4] of WIDTH bits. A write cycle (`enable && write`) overwrites the 8 bytes selected by `idx`.
- Write side effects: every write cycle also clears all accumulators, PE pipeline registers and the step counter `t`.
- Compute cycle (`enable && !write`) while `t < 10`:
  - Edge inputs at step t: row i receives A[i][t-i] and column j receives B[t-j][j] when the index is in 0..3; otherwise the edge input is 0.
  - PE(i,j) does acc += a_in*b_in, a_out <= a_in, b_out <= b_in.
  - a_in comes from the row edge for j=0, else from a_out of PE(i,j-1). b_in comes from the column edge for i=0, else from b_out of PE(i-1,j).
  - t increments.
- When `t == 10`: compute cycles are no-ops, accumulators hold, `done` = 1. `done` = (t == 10), combinational from the counter.
- Arithmetic: unsigned operands, full 2*WIDTH product, zero-extended to ACC_W, accumulation modulo 2^ACC_W. The default of 18 bits holds the maximum 4*255*255 = 260100 without wrap.
- Priority: `reset` > `enable`=0 (hold) > `write` > compute.

## Timing
- Reset: A, B, all accumulators, pipeline registers and t cleared to 0. All `y` = 0 and `done` = 0 on the cycle after reset.
- Load: data is written at the edge ending the write cycle and is usable by the next compute cycle.
- Latency: 10 consecutive enabled compute cycles after the last write. The `y` outputs are final and `done` rises after the 10th edge.
- `enable` low mid-compute: pauses with no state change; the sequence resumes where it left off.
- `write` mid-compute: aborts the pass. The pass restarts from t = 0 on the next compute cycle using the updated operands.
- `reset` mid-operation: same as power-up reset; the operands are lost.
- Back-to-back compute after `done`: outputs stay stable indefinitely.

## Configuration
- `RF_SYSTOLIC_SIGNED_EN` defined: operands are two's complement. Products are signed, sign-extended to ACC_W and accumulated in two's complement; the `y` outputs are signed.
- Not defined: unsigned arithmetic as described above.

## Test plan
- Identity: load A = I, B with B[r][c] = 4r+c+1 -> after 10 compute cycles `y(4i+j)` = 4i+j+1, `done` = 1. `done` = 0 after 9 compute cycles.
- Saturation check: A = B = all 255 -> every `y` = 260100. With `RF_SYSTOLIC_SIGNED_EN`, A = all 0xFF (-1) and B = all 2 -> every `y` = -8 in 18-bit two's complement.
- Pause: in the identity test, drop `enable` for 3 cycles at t = 5 -> results and `done` are delayed exactly 3 cycles; values unchanged.
- Abort: a write at t = 4 that reloads B = all 1 with A = I -> t and the accumulators restart from 0, the pass finishes 10 compute cycles later, and every `y` = 1.
- Reset: assert `reset` with `enable` = 0 after `done` -> all `y` = 0 and `done` = 0. A compute pass without reloading then yields all 0.
- Load mapping: write `idx` = 1 with d0..d7 = 1..8, then compute with B = I -> y8..y11 = 1..4 and y12..y15 = 5..8; all other `y` = 0.
